// File: rtl/soc_system_pio_ext.sv
// Avalon-MM parallel I/O port: output register with set/clear access, synchronised input readback.
// Optional edge capture, IRQMASK and irq logic are enabled by defining PIO_EDGE_IRQ_EN.
module soc_system_pio_ext #(
    parameter int                    DATA_WIDTH  = 8,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = {DATA_WIDTH{1'b0}},
    parameter int                    EDGE_TYPE   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_OUTREAD = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    logic                  wr_en_s;
    logic [DATA_WIDTH-1:0] wdata_s;
    logic                  unused_wdata_s;

    logic [DATA_WIDTH-1:0] out_d,   out_q;
    logic [DATA_WIDTH-1:0] sync1_d, sync1_q;
    logic [DATA_WIDTH-1:0] sync2_d, sync2_q;
    logic [DATA_WIDTH-1:0] rd_s;

    assign wr_en_s        = chipselect & ~write_n;
    assign wdata_s        = writedata[DATA_WIDTH-1:0];
    assign unused_wdata_s = ^writedata;
    assign out_port       = out_q;

    // Output register next state: plain load, atomic OR-set and AND-NOT-clear.
    always_comb begin
        out_d = out_q;
        if (wr_en_s) begin
            case (address)
                ADDR_DATA:   out_d = wdata_s;
                ADDR_OUTSET: out_d = out_q | wdata_s;
                ADDR_OUTCLR: out_d = out_q & ~wdata_s;
                default:     out_d = out_q;
            endcase
        end else begin
            out_d = out_q;
        end
    end

    // Two-stage synchroniser for the asynchronous inputs.
    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
    end

`ifdef PIO_EDGE_IRQ_EN
    logic [DATA_WIDTH-1:0] prev_d, prev_q;
    logic [DATA_WIDTH-1:0] mask_d, mask_q;
    logic [DATA_WIDTH-1:0] cap_d,  cap_q;
    logic [DATA_WIDTH-1:0] edge_s;
    logic [DATA_WIDTH-1:0] clr_s;
    logic                  irq_d,  irq_q;

    assign irq = irq_q;

    // Edge detection, sticky capture (set beats clear) and interrupt mask.
    always_comb begin
        prev_d = sync2_q;
        if (EDGE_TYPE == 32'sd0) begin
            edge_s = sync2_q & ~prev_q;
        end else if (EDGE_TYPE == 32'sd1) begin
            edge_s = ~sync2_q & prev_q;
        end else begin
            edge_s = sync2_q ^ prev_q;
        end
        if (wr_en_s && (address == ADDR_EDGECAP)) begin
            clr_s = wdata_s;
        end else begin
            clr_s = {DATA_WIDTH{1'b0}};
        end
        if (wr_en_s && (address == ADDR_IRQMASK)) begin
            mask_d = wdata_s;
        end else begin
            mask_d = mask_q;
        end
        cap_d = (cap_q & ~clr_s) | edge_s;
        irq_d = |(cap_q & mask_q);
    end

    // Edge/interrupt state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            prev_q <= {DATA_WIDTH{1'b0}};
            mask_q <= {DATA_WIDTH{1'b0}};
            cap_q  <= {DATA_WIDTH{1'b0}};
            irq_q  <= 1'b0;
        end else begin
            prev_q <= prev_d;
            mask_q <= mask_d;
            cap_q  <= cap_d;
            irq_q  <= irq_d;
        end
    end
`endif

    // Read mux; independent of chipselect so it depends only on address and state.
    always_comb begin
        rd_s = {DATA_WIDTH{1'b0}};
        case (address)
            ADDR_DATA:    rd_s = sync2_q;
            ADDR_OUTREAD: rd_s = out_q;
`ifdef PIO_EDGE_IRQ_EN
            ADDR_IRQMASK: rd_s = mask_q;
            ADDR_EDGECAP: rd_s = cap_q;
`endif
            default:      rd_s = {DATA_WIDTH{1'b0}};
        endcase
        readdata                   = 32'h0000_0000;
        readdata[DATA_WIDTH-1:0]   = rd_s;
    end

`ifndef PIO_EDGE_IRQ_EN
    assign irq = 1'b0;
`endif

    // Output register and synchroniser flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_q   <= RESET_VALUE;
            sync1_q <= {DATA_WIDTH{1'b0}};
            sync2_q <= {DATA_WIDTH{1'b0}};
        end else begin
            out_q   <= out_d;
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

endmodule
